// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two producers.
// Define FIFO_ARB_FIXED_PRIO_EN to make the idle decision fixed priority (requester 0 wins).
module fifo_wr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              full,
    output logic              ack0,
    output logic              ack1,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last;
    logic             last_nxt;
    logic [1:0]       grant_nxt;
    logic             owner;
    logic             own_req;
    logic             accept;

    // Owner index comes straight from the one-hot grant register.
    assign owner   = grant[1];
    assign own_req = owner ? req1 : req0;
    assign accept  = (state == BURST) && own_req && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            grant <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
            grant <= grant_nxt;
            busy  <= (state_nxt == BURST);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        grant_nxt = grant;
        wr        = accept;
        ack0      = accept && !owner;
        ack1      = accept && owner;
        wdata     = '0;

        if (state == IDLE) begin
            // Arbitration decision; no write happens in this cycle.
            if (req0 || req1) begin
                state_nxt = BURST;
                cnt_nxt   = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
                grant_nxt = req0 ? 2'b01 : 2'b10;
`else
                if (req0 && req1) begin
                    grant_nxt = last ? 2'b01 : 2'b10;
                end else begin
                    grant_nxt = req0 ? 2'b01 : 2'b10;
                end
`endif
            end
        end else begin
            wdata = owner ? data1 : data0;
            // Release on the final word of the burst or when the owner withdraws.
            if (!own_req || (accept && (cnt == CNT_LAST))) begin
                state_nxt = IDLE;
                last_nxt  = owner;
                cnt_nxt   = '0;
                grant_nxt = 2'b00;
            end else if (accept) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_fifo_wr_arbiter;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_LEN = 4;

    logic              clk;
    logic              rst;
    logic              req0, req1, full;
    logic [DATA_W-1:0] data0, data1;
    logic              ack0, ack1, wr, busy;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        grant;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: who owns the port and how many words it has moved.
    int m_owner = -1;
    int m_words = 0;
    int m_last  = 1;

    fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .full(full),
        .ack0(ack0), .ack1(ack1), .wr(wr), .wdata(wdata),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0, r1, f;
        logic [7:0] d0, d1;
        logic [1:0] g;
        logic       b, w, a0, a1;
        logic [7:0] wd;
    } vec_t;

    function automatic logic [13:0] pack(input logic [1:0] g, input logic b, input logic w,
                                         input logic a1, input logic a0, input logic [7:0] wd);
        return {g, b, w, a1, a0, wd};
    endfunction

    function automatic logic [13:0] act_out();
        return pack(grant, busy, wr, ack1, ack0, wdata);
    endfunction

    function automatic logic [13:0] model_out();
        logic acc;
        logic [7:0] d;
        if (m_owner < 0) return 14'd0;
        acc = ((m_owner == 0) ? req0 : req1) && !full;
        d   = (m_owner == 0) ? data0 : data1;
        return pack((m_owner == 0) ? 2'b01 : 2'b10, 1'b1, acc,
                    acc && (m_owner == 1), acc && (m_owner == 0), d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_words = 0;
        m_last  = 1;
    endtask

    // Advance the reference across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit want;
        if (m_owner < 0) begin
            if (req0 || req1) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
                m_owner = req0 ? 0 : 1;
`else
                if (req0 && req1) m_owner = 1 - m_last;
                else              m_owner = req0 ? 0 : 1;
`endif
                m_words = 0;
            end
        end else begin
            want = (m_owner == 0) ? req0 : req1;
            if (want && !full) m_words++;
            if (!want || m_words == BURST_LEN) begin
                m_last  = m_owner;
                m_owner = -1;
                m_words = 0;
            end
        end
    endtask

    // Called at posedge+1: drive, settle, compare against model, then cross the next edge.
    task automatic cycle(input logic r0, input logic r1, input logic f,
                         input logic [7:0] d0, input logic [7:0] d1, input string name);
        req0 = r0; req1 = r1; full = f; data0 = d0; data1 = d1;
        #2;
        chk(name, 32'(act_out()), 32'(model_out()));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; full = 0; data0 = '0; data1 = '0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_outputs", 32'(act_out()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    vec_t tbl[7];
    int   nwr;
    int   nack1;
    logic [1:0] order[$];
    logic [1:0] prev_g;

    initial begin
        rst = 1'b0; req0 = 0; req1 = 0; full = 0; data0 = '0; data1 = '0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_outputs", 32'(act_out()), 32'd0);
        rst = 1'b1;

        // Single producer burst: data 0x10..0x13, then release.
        tbl[0] = '{1, 0, 0, 8'h10, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};
        tbl[1] = '{1, 0, 0, 8'h10, 8'h00, 2'b01, 1, 1, 1, 0, 8'h10};
        tbl[2] = '{1, 0, 0, 8'h11, 8'h00, 2'b01, 1, 1, 1, 0, 8'h11};
        tbl[3] = '{1, 0, 0, 8'h12, 8'h00, 2'b01, 1, 1, 1, 0, 8'h12};
        tbl[4] = '{1, 0, 0, 8'h13, 8'h00, 2'b01, 1, 1, 1, 0, 8'h13};
        tbl[5] = '{0, 0, 0, 8'h14, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};
        tbl[6] = '{0, 1, 1, 8'h00, 8'h55, 2'b00, 0, 0, 0, 0, 8'h00};
        for (int i = 0; i < 7; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; full = tbl[i].f;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
            #2;
            chk($sformatf("vec%0d", i), 32'(act_out()),
                32'(pack(tbl[i].g, tbl[i].b, tbl[i].w, tbl[i].a1, tbl[i].a0, tbl[i].wd)));
            @(posedge clk);
            model_edge();
            #1;
        end
        // Row 6 left req1 requesting with full high: granted regardless of full, but no write.
        cycle(0, 1, 1, 8'h00, 8'h56, "grant_while_full");
        chk("grant_ignores_full", 32'(grant), 32'(2'b10));
        cycle(0, 0, 0, 8'h00, 8'h00, "release_idle");

        // Both requesting continuously: 15 cycles, three bursts.
        do_reset();
        nwr = 0; nack1 = 0; prev_g = 2'b00;
        order.delete();
        for (int c = 0; c < 15; c++) begin
            req0 = 1; req1 = 1; full = 0;
            data0 = 8'(8'h20 + c); data1 = 8'(8'h40 + c);
            #2;
            if (wr) nwr++;
            if (ack1) nack1++;
            if (grant != 2'b00 && prev_g == 2'b00) order.push_back(grant);
            prev_g = grant;
            chk("both_req", 32'(act_out()), 32'(model_out()));
            @(posedge clk);
            model_edge();
            #1;
        end
        chk("both_req_writes", 32'(nwr), 32'd12);
        chk("both_req_bursts", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            chk("order", 32'({order[0], order[1], order[2]}), 32'({2'b01, 2'b01, 2'b01}));
            chk("fixed_no_ack1", 32'(nack1), 32'd0);
`else
            chk("order", 32'({order[0], order[1], order[2]}), 32'({2'b01, 2'b10, 2'b01}));
`endif
        end
        cycle(0, 0, 0, 8'h00, 8'h00, "drain");
        cycle(0, 0, 0, 8'h00, 8'h00, "drain");

        // Stall: full for 3 cycles after the 2nd write, burst then resumes.
        do_reset();
        nwr = 0;
        for (int c = 0; c < 9; c++) begin
            req0 = (c < 8); req1 = 0; full = (c >= 3 && c <= 5);
            data0 = 8'(8'h30 + nwr); data1 = '0;
            #2;
            if (full) chk("stall_no_wr", 32'({wr, ack0}), 32'd0);
            if (wr) nwr++;
            chk("stall", 32'(act_out()), 32'(model_out()));
            @(posedge clk);
            model_edge();
            #1;
        end
        chk("stall_writes", 32'(nwr), 32'd4);
        chk("stall_idle_after", 32'({grant, busy}), 32'd0);

        // Early release by requester 1, then requester 0 wins the next contention.
        do_reset();
        cycle(0, 1, 0, 8'h00, 8'h70, "r1_idle");
        cycle(0, 1, 0, 8'h00, 8'h70, "r1_word");
        cycle(0, 0, 0, 8'h00, 8'h71, "r1_drop");
        cycle(1, 1, 0, 8'h01, 8'h72, "contend_idle");
        chk("after_drop_grant", 32'(grant), 32'(2'b01));
        cycle(0, 0, 0, 8'h00, 8'h00, "release");
        cycle(0, 0, 0, 8'h00, 8'h00, "idle");

        // Asynchronous reset while a write is in progress.
        do_reset();
        cycle(1, 0, 0, 8'h90, 8'h00, "pre_rst");
        cycle(1, 0, 0, 8'h91, 8'h00, "pre_rst");
        req0 = 1; full = 0; data0 = 8'h92;
        #1;
        chk("wr_before_rst", 32'(wr), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst", 32'({wr, ack0, ack1, grant, busy}), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1, 1, 0, 8'hA0, 8'hB0, "post_rst_idle");
        chk("post_rst_grant", 32'(grant), 32'(2'b01));

        // Randomized traffic against the reference.
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
